// File: rtl/seg_scanner.sv
// seg_scanner: four-digit multiplexed 7-segment driver with frame snapshot, leading-zero blanking, dead time and PWM dimming
module seg_scanner #(
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic       blank_lz,
  input  logic [2:0] brightness,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);
  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] DEAD = PW'(DEAD_CYCLES);
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [2:0]    pwm;
  logic [15:0]   snap;
  logic          snap_lz;
  logic          slot_end, frame_end, lit, blank;
  logic [3:0]    code, an_d;
  logic [6:0]    dec, seg_d;
  always_comb begin
    slot_end  = presc == LAST;
    frame_end = slot_end && idx == 2'd3;
    code      = snap[{idx, 2'b00} +: 4];
    blank     = snap_lz && ((idx == 2'd3 && snap[15:12] == 4'h0) || (idx == 2'd2 && snap[15:8] == 8'h00));
    lit       = presc >= DEAD && pwm <= brightness;
    an_d      = lit ? ~(4'b0001 << idx) : 4'hF;
    case (code)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
    seg_d = blank ? 7'h7F : dec;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      pwm        <= '0;
      snap       <= '0;
      snap_lz    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
    end else begin
      presc      <= slot_end ? '0 : presc + 1'b1;
      idx        <= slot_end ? idx + 2'd1 : idx;
      pwm        <= pwm + 3'd1;
      frame_tick <= frame_end;
      an         <= an_d;
      seg        <= seg_d;
      if (frame_end) begin
        snap    <= {digit3, digit2, digit1, digit0};
        snap_lz <= blank_lz;
      end
    end
  end
endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed and randomized checks of seg_scanner against a cycle-count arithmetic model
module tb_seg_scanner;
  localparam int SLOT = 8;
  localparam int DEAD = 2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit3 = 4'h0, digit2 = 4'h0, digit1 = 4'h0, digit0 = 4'h0;
  logic       blank_lz = 1'b0;
  logic [2:0] brightness = 3'd7;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;
  int tests = 0;
  int fails = 0;
  seg_scanner #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .blank_lz(blank_lz), .brightness(brightness), .an(an), .seg(seg), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int n = 0;
  int phase, slot;
  logic [3:0] msnap [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic       mlz = 1'b0;
  logic       mblank;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_ft = 1'b0;
  // Model: n edges since reset release; slot, phase and PWM count all follow from n.
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      msnap = '{4'h0, 4'h0, 4'h0, 4'h0};
      mlz = 1'b0;
      exp_an = 4'hF;
      exp_seg = 7'h7F;
      exp_ft = 1'b0;
    end else begin
      phase = n % SLOT;
      slot = (n / SLOT) % 4;
      exp_an = (phase >= DEAD && (n % 8) <= int'(brightness)) ? ~(4'b0001 << slot) : 4'hF;
      mblank = mlz && ((slot == 3 && msnap[3] == 4'h0) || (slot == 2 && msnap[3] == 4'h0 && msnap[2] == 4'h0));
      exp_seg = mblank ? 7'h7F : seg_tab[msnap[slot]];
      exp_ft = (n % (4 * SLOT)) == 4 * SLOT - 1;
      if (exp_ft) begin
        msnap = '{digit0, digit1, digit2, digit3};
        mlz = blank_lz;
      end
      n++;
    end
  end
  task automatic check();
    tests += 4;
    assert (an === exp_an) else begin fails++; $error("FAIL an obs=%h exp=%h n=%0d", an, exp_an, n); end
    assert (seg === exp_seg) else begin fails++; $error("FAIL seg obs=%h exp=%h n=%0d", seg, exp_seg, n); end
    assert (frame_tick === exp_ft) else begin fails++; $error("FAIL frame_tick obs=%b exp=%b n=%0d", frame_tick, exp_ft, n); end
    assert ($countones(~an) <= 1) else begin fails++; $error("FAIL onehot obs=%h exp=<=1 low n=%0d", an, n); end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      check();
    end
  endtask
  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask
  initial begin
    int cnt;
    step(3);
    rst_n = 1'b1;
    set_digits(4'h1, 4'h2, 4'h3, 4'h4);
    step(3 * 4 * SLOT);
    set_digits(4'h0, 4'h0, 4'h5, 4'h0);
    blank_lz = 1'b1;
    step(2 * 4 * SLOT);
    set_digits(4'h1, 4'h0, 4'h0, 4'h0);
    blank_lz = 1'b0;
    step(4 * SLOT + 12);
    digit3 = 4'h9;
    step(2 * 4 * SLOT);
    brightness = 3'd0;
    step(4 * SLOT);
    brightness = 3'd5;
    cnt = 0;
    while ((n / SLOT) % 4 != 2 && cnt < 64) begin step(1); cnt++; end
    tests++;
    assert (cnt < 64) else begin fails++; $error("FAIL reach_idx2 obs=%0d exp=<64", cnt); end
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    cnt = 0;
    do begin step(1); cnt++; end while (frame_tick !== 1'b1 && cnt < 64);
    tests++;
    assert (cnt == 4 * SLOT) else begin fails++; $error("FAIL first_tick obs=%0d exp=%0d", cnt, 4 * SLOT); end
    set_digits(4'hE, 4'hD, 4'h0, 4'h0);
    brightness = 3'd7;
    step(2 * 4 * SLOT);
    blank_lz = 1'b1;
    step(2 * 4 * SLOT);
    for (int i = 0; i < 20 * 4 * SLOT; i++) begin
      if ($urandom_range(15) == 0) set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(7) == 0) set_digits(4'h0, 4'h0, 4'($urandom), 4'($urandom));
      if ($urandom_range(31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(7) == 0) brightness = 3'($urandom);
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
